// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Loadable instruction memory for the single-issue core. A program image is
//   streamed in over a valid/ready load port at boot or on reload. It is then
//   served to the fetch stage with a registered read of one cycle. Word indices
//   at or beyond the loaded program length read as NOP_WORD.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   load_start              pulse: begin (re)load of the program image
//   load_valid/load_data    word offered by the loader
//   load_last               marks the final word of the image (with load_valid)
//   load_ready              memory accepts a word this cycle (registered)
//   load_done               level: image loaded, memory serving fetches
//   load_err                level: memory filled without seeing load_last
//   prog_len                number of words loaded (0..DEPTH)
//   fetch_en, pc            fetch request for word index pc
//   instr_out, instr_valid  registered fetch result, valid for one cycle
//   dbg_state               current FSM state (0 IDLE, 1 LOAD, 2 RUN)
//
// Handshake: a word moves on a rising edge where load_valid and load_ready are
// both high. The loader may hold load_valid low for any number of cycles
// (bubbles). load_ready never depends combinationally on load_valid.
module instr_mem_loader #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = 6,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_en,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic transfer;
  logic last_slot;
  logic load_final;
  logic reload;
  logic fetch_hit;
  logic in_range;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (load_start) next_state = S_LOAD;
      S_LOAD:  if (load_final) next_state = S_RUN;
      S_RUN:   if (load_start) next_state = S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  // Decoded control signals
  always_comb begin
    transfer   = (state == S_LOAD) && load_valid && load_ready;
    last_slot  = (wr_ptr == ADDR_W'(DEPTH - 1));
    // The image ends on load_last. It also ends when the last slot is written.
    load_final = transfer && (load_last || last_slot);
    // load_start is ignored while a load is already in progress.
    reload     = load_start && (state != S_LOAD);
    // A reload request beats a fetch request on the same cycle.
    fetch_hit  = (state == S_RUN) && fetch_en && !load_start;
    // prog_len <= DEPTH, so any pc with upper bits set also fails this test.
    in_range   = (pc < 32'(prog_len));
    dbg_state  = state;
  end

  // Load bookkeeping: write pointer, length and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ready <= 1'b0;
      wr_ptr     <= '0;
      prog_len   <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_ready <= (next_state == S_LOAD);
      if (reload) begin
        wr_ptr    <= '0;
        prog_len  <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else if (transfer) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (load_final) begin
          prog_len  <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
          load_done <= 1'b1;
          load_err  <= !load_last;
        end
      end
    end
  end

  // Storage is not reset; prog_len = 0 masks stale contents.
  always_ff @(posedge clk) begin
    if (transfer) mem[wr_ptr] <= load_data;
  end

  // Registered fetch port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (fetch_hit) begin
      instr_out   <= in_range ? mem[pc[ADDR_W-1:0]] : NOP_WORD;
      instr_valid <= 1'b1;
    end else if ((state == S_RUN) && !load_start) begin
      instr_valid <= 1'b0;   // idle cycle in RUN: hold the last word
    end else begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Bench for instr_mem_loader. A reference model holds the loaded image as an
//   array plus a length. Expected fetch results come from that model.
module tb_instr_mem_loader;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [DATA_W-1:0] NOP = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              load_start, load_valid, load_last, fetch_en;
  logic [DATA_W-1:0] load_data;
  logic [31:0]       pc;
  logic              load_ready, load_done, load_err, instr_valid;
  logic [ADDR_W:0]   prog_len;
  logic [DATA_W-1:0] instr_out;
  logic [1:0]        dbg_state;

  instr_mem_loader #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_err(load_err), .prog_len(prog_len),
    .fetch_en(fetch_en), .pc(pc), .instr_out(instr_out),
    .instr_valid(instr_valid), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_len;
  bit                ref_done, ref_err;
  logic [DATA_W-1:0] img [DEPTH];

  function automatic logic [DATA_W-1:0] ref_fetch(input logic [31:0] p);
    if (p < 32'(ref_len)) return ref_mem[p[ADDR_W-1:0]];
    return NOP;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [31:0]       pc_list [$];
  logic [DATA_W-1:0] last_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens on the falling edge; outputs are sampled there too.
  task automatic load_image(input int n, input bit with_last, input int gap_mode);
    load_start = 1'b1;
    fetch_en   = 1'b1;   // a concurrent fetch must lose to the reload
    pc         = 32'h0;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en   = 1'b0;
    ref_len = 0; ref_done = 0; ref_err = 0;
    check_eq("start_ready", 64'(load_ready), 64'd1);
    check_eq("start_done",  64'(load_done),  64'(ref_done));
    check_eq("start_err",   64'(load_err),   64'(ref_err));
    check_eq("start_len",   64'(prog_len),   64'(ref_len));
    check_eq("start_valid", 64'(instr_valid), 64'd0);
    check_eq("start_instr", 64'(instr_out),  64'(NOP));
    for (int i = 0; i < n; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        load_valid = 1'b0;
        load_data  = $urandom;
        load_last  = 1'($urandom_range(0, 1));   // ignored without load_valid
        @(negedge clk);
      end
      check_eq("load_ready", 64'(load_ready), 64'd1);
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = with_last && (i == n - 1);
      @(negedge clk);
      ref_mem[i] = img[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    ref_len  = n;
    ref_done = 1'b1;
    ref_err  = !with_last;
    check_eq("end_len",   64'(prog_len),   64'(ref_len));
    check_eq("end_done",  64'(load_done),  64'(ref_done));
    check_eq("end_err",   64'(load_err),   64'(ref_err));
    check_eq("end_ready", 64'(load_ready), 64'd0);
  endtask

  // Issues every pc in pc_list back-to-back, then one idle cycle.
  task automatic run_fetches();
    foreach (pc_list[k]) begin
      pc       = pc_list[k];
      fetch_en = 1'b1;
      exp_q.push_back(ref_fetch(pc_list[k]));
      @(negedge clk);
      last_exp = exp_q.pop_front();
      check_eq("fetch_data",  64'(instr_out),   64'(last_exp));
      check_eq("fetch_valid", 64'(instr_valid), 64'd1);
    end
    fetch_en = 1'b0;
    pc       = $urandom;
    @(negedge clk);
    check_eq("idle_valid", 64'(instr_valid), 64'd0);
    check_eq("idle_hold",  64'(instr_out),   64'(last_exp));
    pc_list.delete();
  endtask

  task automatic fill_random_image();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_en = 0; pc = '0;
    ref_len = 0; ref_done = 0; ref_err = 0; last_exp = NOP;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(load_ready), 64'd0);
    check_eq("rst_done",  64'(load_done),  64'd0);
    check_eq("rst_err",   64'(load_err),   64'd0);
    check_eq("rst_len",   64'(prog_len),   64'd0);
    check_eq("rst_instr", 64'(instr_out),  64'(NOP));
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 12-word image with known words at 0, 2 and 11.
    fill_random_image();
    img[0]  = 32'h71041000;
    img[2]  = 32'hF2400001;
    img[11] = 32'hB0090000;
    load_image(12, 1'b1, 0);
    pc_list = '{32'd0, 32'd2, 32'd11};
    run_fetches();
    check_eq("known_w11", 64'(last_exp), 64'h00000000B0090000);
    pc_list = '{32'd12, 32'h0000_0100};
    run_fetches();

    // Same image with a bubble before every word.
    load_image(12, 1'b1, 1);
    for (int i = 0; i <= 12; i++) pc_list.push_back(32'(i));
    run_fetches();

    // Full memory with no load_last: error flag and full length.
    fill_random_image();
    load_image(DEPTH, 1'b0, 0);
    pc_list = '{32'd63, 32'd0, 32'd62, 32'd64, 32'hFFFF_FFC0};
    run_fetches();

    // Random images, random bubbles and random fetch addresses.
    for (int r = 0; r < 4; r++) begin
      int n;
      bit wl;
      fill_random_image();
      n  = $urandom_range(1, DEPTH);
      wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      load_image(n, wl, 2);
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 7) == 0) pc_list.push_back($urandom);
        else                           pc_list.push_back(32'($urandom_range(0, DEPTH + 6)));
      end
      run_fetches();
    end

    // Reset partway through a 12-word load.
    fill_random_image();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      @(negedge clk);
      ref_mem[i] = img[i];
    end
    load_data = img[5];
    #2 reset = 1'b1;
    #1;
    ref_len = 0; ref_done = 0; ref_err = 0;
    check_eq("arst_len",   64'(prog_len),    64'd0);
    check_eq("arst_ready", 64'(load_ready),  64'd0);
    check_eq("arst_done",  64'(load_done),   64'd0);
    check_eq("arst_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    load_valid = 1'b0;
    reset      = 1'b0;
    fetch_en   = 1'b1;   // fetches in IDLE are ignored
    pc         = 32'd1;
    @(negedge clk);
    check_eq("idle_fetch_valid", 64'(instr_valid), 64'd0);
    check_eq("idle_fetch_instr", 64'(instr_out),   64'(NOP));
    fetch_en = 1'b0;
    fill_random_image();
    img[5] = ~ref_mem[5];   // guarantee the reloaded word differs
    load_image(12, 1'b1, 0);
    pc_list = '{32'd5, 32'd0, 32'd11, 32'd12};
    run_fetches();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
